uart_baud_gen_frac: RTL and testbench
=====================================

Name: uart_baud_gen_frac

Overview:
Parametrised UART baud generator with a fractional divisor. It produces the shared oversample tick, the RX mid-bit sample strobe and the TX bit-boundary strobe. It sits between the divisor registers (DLH/DLL/DLF) and the UART RX/TX shifters, and replaces the fixed ×16, integer-only generator. It adds a programmable oversample ratio, a programmable sample point, glitch-free divisor update, an enable, and divisor-error detection.

Parameters:
INT_WIDTH, 16, integer divisor width (div_int).
FRAC_WIDTH, 4, fractional divisor width; the fractional step is 1/2^FRAC_WIDTH.
OVS, 16, os_ticks per bit; must be a power of two, 4..16. PH_W = log2(OVS).

Ports:
pclk  in  1  clock
presetn  in  1  reset, asynchronous, active-low
enable  in  1  run; when low, all counters hold
div_int  in  INT_WIDTH  integer divisor, in pclk per os_tick
div_frac  in  FRAC_WIDTH  fractional divisor
div_update  in  1  1-cycle pulse; loads div_int/div_frac into the active registers
sample_pt  in  PH_W  RX phase at which sample_edge fires (legacy value OVS/2-1)
rx_clr  in  1  resynchronise RX phase (start-bit detect)
tx_clr  in  1  resynchronise TX phase (start of frame)
os_tick  out  1  oversample tick pulse
sample_edge  out  1  RX sample strobe
transmit_edge  out  1  TX bit-boundary strobe
div_err  out  1  active integer divisor == 0

Behaviour:
- Reset: active divisor = 0; presc_cnt = 1; acc = 0; carry = 0; rx_ph = tx_ph = 0; all outputs 0. div_err becomes 1 on the first clock after reset (divisor 0).
- Active regs div_int_q/div_frac_q load only on div_update, which is honoured regardless of enable.
  - The same edge sets presc_cnt=1, acc=0, carry=0, rx_ph=0, tx_ph=0. div_update has priority over rx_clr/tx_clr.
  - div_err <= (new div_int == 0).
- period = div_int_q + carry. presc_cnt is INT_WIDTH+1 bits, so there is no overflow at div_int = max with carry = 1.
- Internal tick: tick_i = enable & ~div_err & (presc_cnt == period).
- Prescaler, when enable & ~div_err:
  - If tick_i: presc_cnt <= 1 and {carry, acc} <= acc + div_frac_q (FRAC_WIDTH+1-bit sum).
  - Otherwise: presc_cnt increments.
  - Average period = div_int_q + div_frac_q/2^FRAC_WIDTH; the error over 2^FRAC_WIDTH ticks is exactly 0.
  - The first period after update is div_int_q (carry = 0).
- enable low: presc_cnt, acc, carry, rx_ph, tx_ph hold; no pulses. On resume, the remaining count continues.
- div_err = 1: counters held at their update values; no pulses.
- RX phase:
  - rx_clr: rx_ph <= 0; sample_edge is suppressed that cycle.
  - Else if tick_i: rx_ph <= rx_ph + 1, wrapping OVS-1 -> 0.
- TX phase: same rules with tx_clr/tx_ph.
- rx_clr/tx_clr do not touch the prescaler; the phase uncertainty is < 1 os_tick.
- Outputs are registered, one pclk after the internal match, and mutually aligned:
  - os_tick <= tick_i
  - sample_edge <= tick_i & ~rx_clr & (rx_ph == sample_pt)
  - transmit_edge <= tick_i & ~tx_clr & (tx_ph == OVS-1)
- All strobes are exactly 1 pclk wide. With div_int_q=1, div_frac_q=0, os_tick stays high continuously: 1 tick per cycle.
- sample_pt is sampled live. Changing it mid-bit may skip or duplicate one sample; software must change it only while RX is idle.
- Asynchronous reset mid-operation: all state and outputs go to 0 immediately.

Test Plan:
1. OVS=16, div_int=4, div_frac=0, sample_pt=7, enable=1, div_update pulse at edge E0 -> first os_tick 4 pclk after E0, then every 4. sample_edge on the 8th os_tick and every 64 pclk after. transmit_edge on the 16th os_tick and every 64 pclk after. div_err=0.
2. div_int=3, div_frac=8 -> os_tick periods 3,3,4,3,4,3,... The 16th os_tick occurs 55 pclk after the first period starts; 32 ticks take exactly 112 pclk ±1 of phase.
3. div_int=4, rx_clr pulsed when rx_ph=3 -> next sample_edge on the 8th os_tick after the clear. A second rx_clr coincident with the sample tick -> no sample_edge that cycle, rx_ph=0.
4. After reset with no update -> div_err=1 and no strobes for 1000 cycles. Then div_update with div_int=1, frac=0 -> div_err=0 next cycle, os_tick high every cycle, transmit_edge every 16 pclk.
5. div_int=10, enable dropped 6 pclk into a period for 20 cycles -> no strobes while low; the next os_tick comes 4 pclk after re-enable. presetn asserted mid-bit -> all outputs 0 asynchronously, div_err=1 after release.
6. div_int=65535, div_frac=15 -> periods 65535 then 65536 ×15 per 16 ticks; no counter wrap; div_update mid-period restarts the count from 1 with no runt or double tick.

Source files
------------

// File: rtl/uart_baud_gen_frac.sv
// Fractional-divisor UART baud generator: oversample tick, RX mid-bit sample strobe
// and TX bit-boundary strobe, all registered and mutually aligned.
module uart_baud_gen_frac #(
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4,
    parameter int OVS        = 16,
    localparam int PH_W      = $clog2(OVS)
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  enable,
    input  logic [INT_WIDTH-1:0]  div_int,
    input  logic [FRAC_WIDTH-1:0] div_frac,
    input  logic                  div_update,
    input  logic [PH_W-1:0]       sample_pt,
    input  logic                  rx_clr,
    input  logic                  tx_clr,
    output logic                  os_tick,
    output logic                  sample_edge,
    output logic                  transmit_edge,
    output logic                  div_err
);

    localparam logic [INT_WIDTH:0] PRESC_ONE = (INT_WIDTH+1)'(1);
    localparam logic [PH_W-1:0]    PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0]    PH_LAST   = PH_W'(OVS - 1);

    logic [INT_WIDTH-1:0]  div_int_q;
    logic [FRAC_WIDTH-1:0] div_frac_q;
    logic                  div_err_q;
    logic [INT_WIDTH:0]    presc_cnt;
    logic [INT_WIDTH:0]    period;
    logic [FRAC_WIDTH-1:0] acc;
    logic                  carry;
    logic [FRAC_WIDTH:0]   acc_sum;
    logic [PH_W-1:0]       rx_ph;
    logic [PH_W-1:0]       tx_ph;
    logic                  run;
    logic                  tick_i;

    // Extra bit on presc_cnt/period lets div_int = max plus carry count without wrapping.
    assign period  = {1'b0, div_int_q} + {{INT_WIDTH{1'b0}}, carry};
    assign acc_sum = {1'b0, acc} + {1'b0, div_frac_q};
    assign run     = enable & ~div_err_q;
    assign tick_i  = run & (presc_cnt == period);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            div_int_q  <= '0;
            div_frac_q <= '0;
            div_err_q  <= 1'b0;
        end else if (div_update) begin
            div_int_q  <= div_int;
            div_frac_q <= div_frac;
            div_err_q  <= (div_int == '0);
        end else begin
            div_err_q  <= (div_int_q == '0);
        end
    end

    // The accumulator carry stretches the following period by one pclk.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            presc_cnt <= PRESC_ONE;
            acc       <= '0;
            carry     <= 1'b0;
        end else if (div_update) begin
            presc_cnt <= PRESC_ONE;
            acc       <= '0;
            carry     <= 1'b0;
        end else if (tick_i) begin
            presc_cnt    <= PRESC_ONE;
            {carry, acc} <= acc_sum;
        end else if (run) begin
            presc_cnt <= presc_cnt + PRESC_ONE;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rx_ph <= '0;
            tx_ph <= '0;
        end else if (div_update) begin
            rx_ph <= '0;
            tx_ph <= '0;
        end else begin
            if (rx_clr) begin
                rx_ph <= '0;
            end else if (tick_i) begin
                rx_ph <= rx_ph + PH_ONE;
            end
            if (tx_clr) begin
                tx_ph <= '0;
            end else if (tick_i) begin
                tx_ph <= tx_ph + PH_ONE;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            os_tick       <= 1'b0;
            sample_edge   <= 1'b0;
            transmit_edge <= 1'b0;
        end else begin
            os_tick       <= tick_i;
            sample_edge   <= tick_i & ~rx_clr & (rx_ph == sample_pt);
            transmit_edge <= tick_i & ~tx_clr & (tx_ph == PH_LAST);
        end
    end

    assign div_err = div_err_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: tick-schedule reference model checked every cycle,
// directed timing checks with hand-computed literals, and a randomized phase.
module tb_uart_baud_gen_frac;

    localparam int OVS = 16;
    localparam int FW  = 4;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        div_update = 1'b0;
    logic [3:0]  sample_pt = 4'd7;
    logic        rx_clr = 1'b0;
    logic        tx_clr = 1'b0;
    logic        os_tick, sample_edge, transmit_edge, div_err;

    int n_checks = 0;
    int n_errors = 0;

    uart_baud_gen_frac #(.INT_WIDTH(16), .FRAC_WIDTH(4), .OVS(OVS)) dut (
        .pclk(pclk), .presetn(presetn), .enable(enable),
        .div_int(div_int), .div_frac(div_frac), .div_update(div_update),
        .sample_pt(sample_pt), .rx_clr(rx_clr), .tx_clr(tx_clr),
        .os_tick(os_tick), .sample_edge(sample_edge),
        .transmit_edge(transmit_edge), .div_err(div_err)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tick k (0-based since the last update) ends a period of
    // D + (floor(k*f/2^FW) - floor((k-1)*f/2^FW)) enabled pclks.
    longint m_d = 0, m_f = 0, m_k = 0, m_el = 0;
    int     m_rx = 0, m_tx = 0;
    bit     m_err = 0;
    bit     e_os = 0, e_se = 0, e_te = 0, e_err = 0;

    function automatic longint model_period(longint k);
        if (k == 0) return m_d;
        return m_d + (k * m_f) / (2 ** FW) - ((k - 1) * m_f) / (2 ** FW);
    endfunction

    initial begin
        forever begin
            @(posedge pclk or negedge presetn);
            if (!presetn) begin
                m_d = 0; m_f = 0; m_k = 0; m_el = 0; m_rx = 0; m_tx = 0; m_err = 0;
                e_os = 0; e_se = 0; e_te = 0; e_err = 0;
            end else begin
                bit t;
                t = enable && !m_err && (m_el + 1 == model_period(m_k));
                e_os = t;
                e_se = t && !rx_clr && (m_rx == int'(sample_pt));
                e_te = t && !tx_clr && (m_tx == OVS - 1);
                if (div_update) begin
                    m_d = div_int; m_f = div_frac; m_k = 0; m_el = 0;
                    m_rx = 0; m_tx = 0; m_err = (div_int == 0);
                end else begin
                    if (enable && !m_err) begin
                        if (t) begin m_k++; m_el = 0; end
                        else m_el++;
                    end
                    m_err = (m_d == 0);
                    if (rx_clr) m_rx = 0; else if (t) m_rx = (m_rx + 1) % OVS;
                    if (tx_clr) m_tx = 0; else if (t) m_tx = (m_tx + 1) % OVS;
                end
                e_err = m_err;
            end
        end
    end

    initial begin
        forever begin
            @(negedge pclk);
            chk("os_tick", os_tick, e_os);
            chk("sample_edge", sample_edge, e_se);
            chk("transmit_edge", transmit_edge, e_te);
            chk("div_err", div_err, e_err);
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_update(input int di, input int df);
        div_int = 16'(di);
        div_frac = 4'(df);
        div_update = 1'b1;
        step();
        div_update = 1'b0;
    endtask

    // Cycles until selected strobe (0 os_tick, 1 sample_edge, 2 transmit_edge) is seen.
    task automatic cycles_until(input int sel, input int limit, output int n);
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < limit) begin
            step();
            n++;
            hit = (sel == 0) ? os_tick : (sel == 1) ? sample_edge : transmit_edge;
        end
    endtask

    task automatic cycles_to_ticks(input int nt, input int limit, output int n);
        int t = 0;
        n = 0;
        while (t < nt && n < limit) begin
            step();
            n++;
            if (os_tick) t++;
        end
    endtask

    task automatic ticks_to_sample(input int limit, output int t);
        int n = 0;
        bit hit = 0;
        t = 0;
        while (!hit && n < limit) begin
            step();
            n++;
            if (os_tick) t++;
            hit = sample_edge;
        end
    endtask

    initial begin
        int n, n2, cnt;

        #1;
        chk("reset_os_tick", os_tick, 0);
        chk("reset_div_err", div_err, 0);
        repeat (3) step();
        presetn = 1'b1;
        enable = 1'b1;
        chk("div_err_before_clock", div_err, 0);
        step();
        chk("div_err_first_clock", div_err, 1);

        // Zero divisor: no strobes at all.
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            cnt += int'(os_tick) + int'(sample_edge) + int'(transmit_edge);
        end
        chk("zero_div_strobes", cnt, 0);
        chk("zero_div_err", div_err, 1);

        pulse_update(1, 0);
        chk("div1_err_cleared", div_err, 0);
        cycles_until(2, 100, n);
        chk("div1_first_tx", n, 16);
        cycles_until(2, 100, n);
        chk("div1_tx_spacing", n, 16);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin step(); cnt += int'(os_tick); end
        chk("div1_os_every_cycle", cnt, 20);

        // Integer divisor 4, sample point 7.
        sample_pt = 4'd7;
        pulse_update(4, 0);
        cycles_until(0, 100, n);
        chk("div4_first_os", n, 4);
        cycles_until(1, 200, n);
        chk("div4_first_sample", n, 28);
        cycles_until(2, 200, n);
        chk("div4_first_tx", n, 32);
        cycles_until(2, 200, n);
        chk("div4_tx_spacing", n, 64);
        chk("div4_err", div_err, 0);

        // Fractional 3 + 8/16.
        pulse_update(3, 8);
        cycles_to_ticks(16, 500, n);
        chk("frac_16_ticks", n, 55);
        cycles_to_ticks(16, 500, n2);
        chk("frac_32_ticks", n + n2, 111);

        // RX resync.
        pulse_update(4, 0);
        cycles_to_ticks(3, 100, n);
        rx_clr = 1'b1;
        step();
        rx_clr = 1'b0;
        ticks_to_sample(500, n);
        chk("rxclr_ticks_to_sample", n, 8);
        cycles_to_ticks(15, 500, n);
        repeat (3) step();
        rx_clr = 1'b1;
        step();
        rx_clr = 1'b0;
        chk("rxclr_coinc_os", os_tick, 1);
        chk("rxclr_coinc_no_sample", sample_edge, 0);
        ticks_to_sample(500, n);
        chk("rxclr_coinc_next_sample", n, 8);

        // Enable pause mid-period.
        pulse_update(10, 0);
        repeat (6) step();
        enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt += int'(os_tick) + int'(sample_edge) + int'(transmit_edge);
        end
        chk("paused_strobes", cnt, 0);
        enable = 1'b1;
        cycles_until(0, 100, n);
        chk("resume_os", n, 4);

        // Asynchronous reset while ticking every cycle.
        pulse_update(1, 0);
        repeat (3) step();
        chk("pre_reset_os", os_tick, 1);
        #1;
        presetn = 1'b0;
        #1;
        chk("async_rst_os", os_tick, 0);
        chk("async_rst_err", div_err, 0);
        step();
        presetn = 1'b1;
        step();
        chk("post_reset_err", div_err, 1);

        // Maximum divisor, then restart mid-period.
        pulse_update(65535, 15);
        cycles_until(0, 70000, n);
        chk("max_div_first_os", n, 65535);
        repeat (1000) step();
        chk("max_div_no_early_os", os_tick, 0);
        pulse_update(5, 0);
        cycles_until(0, 100, n);
        chk("restart_os", n, 5);

        // Randomized traffic against the model.
        pulse_update(int'($urandom_range(1, 12)), int'($urandom_range(0, 15)));
        for (int i = 0; i < 3000; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            rx_clr     = ($urandom_range(0, 19) == 0);
            tx_clr     = ($urandom_range(0, 29) == 0);
            div_update = ($urandom_range(0, 149) == 0);
            if (div_update) begin
                div_int  = 16'($urandom_range(0, 12));
                div_frac = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 299) == 0) sample_pt = 4'($urandom_range(0, 15));
            step();
        end
        div_update = 1'b0;
        rx_clr = 1'b0;
        tx_clr = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
